// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the CPU bus master: access sizes, FSM states and the latched request record.
// Also holds the alignment rule used at request acceptance.
package mips_cpu_bus_pkg;

  localparam int BUS_LANES = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Size code 3 is reserved and always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'd3) ||
           ((size == SIZE_HALF) && lane[0]) ||
           ((size == SIZE_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mips_cpu_bus_master_if.sv
// Core request/response handshake plus the memory-side bus, bundled for the bus master.
// master = the bus master block, slave = the core and responder environment around it.
interface mips_cpu_bus_master_if;

  logic                                    req_valid;
  logic                                    req_ready;
  logic                                    req_write;
  logic [1:0]                              req_size;
  logic                                    req_signed;
  logic [31:0]                             req_addr;
  logic [31:0]                             req_wdata;
  logic                                    resp_valid;
  logic [31:0]                             resp_rdata;
  logic                                    resp_err;
  logic [31:0]                             address;
  logic                                    write;
  logic                                    read;
  logic [31:0]                             writedata;
  logic [31:0]                             readdata;
  logic [mips_cpu_bus_pkg::BUS_LANES-1:0]  byteenable;
  logic                                    waitrequest;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           readdata, waitrequest,
    output req_ready, resp_valid, resp_rdata, resp_err,
           address, write, read, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           readdata, waitrequest,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           address, write, read, writedata, byteenable
  );

endinterface

// File: rtl/mips_cpu_bus_lane_align.sv
// Combinational little-endian lane logic: store replication, byteenable, load extract and extend.
// Zero latency, no state; size code 3 yields no lanes and zero data.
module mips_cpu_bus_lane_align
  import mips_cpu_bus_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic [1:0]           lane_i,
  input  logic                 signed_i,
  input  logic [31:0]          wdata_i,
  input  logic [31:0]          rdata_i,
  output logic [BUS_LANES-1:0] byteenable_o,
  output logic [31:0]          wdata_o,
  output logic [31:0]          rdata_o
);

  logic [31:0] rdata_shifted;

  always_comb begin
    byteenable_o  = '0;
    wdata_o       = '0;
    rdata_o       = '0;
    rdata_shifted = rdata_i >> {lane_i, 3'b000};
    case (size_i)
      SIZE_BYTE: begin
        byteenable_o = 4'b0001 << lane_i;
        wdata_o      = {4{wdata_i[7:0]}};
        rdata_o      = {{24{signed_i & rdata_shifted[7]}}, rdata_shifted[7:0]};
      end
      SIZE_HALF: begin
        byteenable_o = 4'b0011 << lane_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{signed_i & rdata_shifted[15]}}, rdata_shifted[15:0]};
      end
      SIZE_WORD: begin
        byteenable_o = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Single-outstanding load/store bus master: write responds 2 cycles after acceptance, read 2+READ_LATENCY; holds while waitrequest.
// Accepts requests only in IDLE. Optional stall abort when MIPS_BUS_TIMEOUT_EN is defined.
module mips_cpu_bus_master
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
`ifdef MIPS_BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input logic                   clk,
  input logic                   reset,
  mips_cpu_bus_master_if.master bus
);

  bus_state_t  state_q, state_d;
  req_t        req_q, req_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  lat_q, lat_d;
  logic        timeout_hit;

  logic [BUS_LANES-1:0] lane_be;
  logic [31:0]          lane_wdata;
  logic [31:0]          lane_rdata;

  mips_cpu_bus_lane_align u_lane_align (
    .size_i       (req_q.size),
    .lane_i       (req_q.addr[1:0]),
    .signed_i     (req_q.sext),
    .wdata_i      (req_q.wdata),
    .rdata_i      (bus.readdata),
    .byteenable_o (lane_be),
    .wdata_o      (lane_wdata),
    .rdata_o      (lane_rdata)
  );

`ifdef MIPS_BUS_TIMEOUT_EN
  logic [15:0] to_q, to_d;

  assign timeout_hit = (to_q == 16'(TIMEOUT_CYCLES));

  // Counts consecutive stalled ISSUE cycles; cleared whenever ISSUE is left.
  always_comb begin
    to_d = '0;
    if ((state_q == ISSUE) && bus.waitrequest && !timeout_hit) begin
      to_d = to_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;

    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.address    = '0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.writedata  = '0;
    bus.byteenable = '0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = !reset;
        if (bus.req_valid) begin
          req_d   = '{write: bus.req_write, size: bus.req_size, sext: bus.req_signed,
                      addr: bus.req_addr, wdata: bus.req_wdata};
          err_d   = is_misaligned(bus.req_size, bus.req_addr[1:0]);
          rdata_d = '0;
          lat_d   = '0;
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          bus.read       = !req_q.write;
          bus.write      = req_q.write;
          bus.address    = {req_q.addr[31:2], 2'b00};
          bus.writedata  = lane_wdata;
          bus.byteenable = lane_be;
          if (!bus.waitrequest) begin
            state_d = req_q.write ? RESP : RDWAIT;
          end
        end
      end
      RDWAIT: begin
        // Data is valid READ_LATENCY cycles after the accepting cycle.
        if (lat_q == 2'(READ_LATENCY - 1)) begin
          rdata_d = lane_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = rdata_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Bench for mips_cpu_bus_master: directed vector table, reset/timeout sequences and random traffic vs a lane model.
// Define MIPS_BUS_TIMEOUT_EN to also exercise the stall abort.
module tb_mips_cpu_bus_master;

  localparam int RL = 1;
  localparam int TO = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mips_cpu_bus_master_if bus ();

`ifdef MIPS_BUS_TIMEOUT_EN
  mips_cpu_bus_master #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`else
  mips_cpu_bus_master #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stalls;
    logic [3:0]  be;
    logic [31:0] wdl;
    logic [31:0] rdx;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // Observations from the last transaction
  int          r_lat;
  int          r_pulses;
  int          r_bus;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_stable;
  logic        r_both;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic        r_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: byte-level view of the access rules.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int stalls,
                       output logic [3:0] be, output logic [31:0] wdl, output logic [31:0] rdx,
                       output logic err, output int lat);
    int n;
    int lane;
    logic [31:0] mask;
    lane = int'(a[1:0]);
    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    n    = 1 << sz;
    be   = '0;
    wdl  = '0;
    rdx  = '0;
    lat  = 1;
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= lane && i < lane + n) be[i] = 1'b1;
        wdl[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      if (!wr) begin
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        rdx  = (rd >> (8 * lane)) & mask;
        if (sx && rdx[8*n-1]) rdx = rdx | ~mask;
      end
      lat = wr ? 2 + stalls : 2 + stalls + RL;
    end
  endtask

  // Called in an IDLE cycle (posedge+1); returns in the IDLE cycle after the response.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int stalls, input bit junk);
    int acc;
    int stall_cnt;
    r_lat = -1; r_pulses = 0; r_bus = 0; r_rdata = '0; r_err = 1'b0; r_stable = 1'b1;
    r_both = 1'b0; r_wr = 1'b0; r_addr = '0; r_be = '0; r_wd = '0;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sx;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    r_ready        = bus.req_ready;
    acc            = -1;
    stall_cnt      = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (junk && r_lat < 0) begin
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.read && bus.write) r_both = 1'b1;
      if (bus.read || bus.write) begin
        if (r_bus == 0) begin
          r_addr = bus.address; r_be = bus.byteenable; r_wd = bus.writedata; r_wr = bus.write;
        end else if (bus.address !== r_addr || bus.byteenable !== r_be ||
                     bus.writedata !== r_wd || bus.write !== r_wr) begin
          r_stable = 1'b0;
        end
        r_bus++;
        bus.waitrequest = (stall_cnt < stalls);
        if (bus.waitrequest) stall_cnt++;
        else acc = c;
      end else begin
        bus.waitrequest = 1'($urandom);
      end
      bus.readdata = (acc > 0 && c == acc + RL) ? rd : $urandom;
      if (bus.resp_valid) begin
        r_pulses++;
        if (r_lat < 0) begin
          r_lat = c; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
        end
      end
      if (r_lat >= 0 && c > r_lat) break;
    end
    bus.req_valid   = 1'b0;
    bus.waitrequest = 1'b0;
  endtask

  task automatic check_txn(input string nm, input logic wr, input logic [31:0] a, input int stalls,
                           input logic [3:0] be, input logic [31:0] wdl, input logic [31:0] rdx,
                           input logic err, input int lat);
    chk($sformatf("%s_ready", nm), 32'(r_ready), 32'd1);
    chk($sformatf("%s_pulses", nm), 32'(r_pulses), 32'd1);
    chk($sformatf("%s_lat", nm), 32'(r_lat), 32'(lat));
    chk($sformatf("%s_err", nm), 32'(r_err), 32'(err));
    chk($sformatf("%s_rdata", nm), r_rdata, rdx);
    if (err) begin
      chk($sformatf("%s_nobus", nm), 32'(r_bus), 32'd0);
    end else begin
      chk($sformatf("%s_buscyc", nm), 32'(r_bus), 32'(stalls + 1));
      chk($sformatf("%s_stable", nm), 32'(r_stable), 32'd1);
      chk($sformatf("%s_both", nm), 32'(r_both), 32'd0);
      chk($sformatf("%s_dir", nm), 32'(r_wr), 32'(wr));
      chk($sformatf("%s_addr", nm), r_addr, {a[31:2], 2'b00});
      chk($sformatf("%s_be", nm), 32'(r_be), 32'(be));
      if (wr) chk($sformatf("%s_wdata", nm), r_wd, wdl);
    end
  endtask

  initial begin
    logic [3:0]  m_be;
    logic [31:0] m_wdl;
    logic [31:0] m_rdx;
    logic        m_err;
    int          m_lat;
    logic        t_wr;
    logic [1:0]  t_sz;
    logic        t_sx;
    logic [31:0] t_a;
    logic [31:0] t_wd;
    logic [31:0] t_rd;
    int          t_st;

    checks   = 0;
    failures = 0;

    //            name        wr    sz    sx    addr          wdata         rdata         st be       wdl           rdx           err  lat
    vecs[0]  = '{"sw_word",   1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 2};
    vecs[1]  = '{"lb_s",      1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 3};
    vecs[2]  = '{"lb_u",      1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0, 3};
    vecs[3]  = '{"sh_stall",  1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_1234, 32'h0,        3, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 5};
    vecs[4]  = '{"lw_mis",    1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        32'h1111_1111, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
    vecs[5]  = '{"lh_s_hi",   1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,        32'hABCD_1234, 0, 4'b1100, 32'h0,        32'hFFFF_ABCD, 1'b0, 3};
    vecs[6]  = '{"lh_u_lo",   1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0,        32'hABCD_8234, 0, 4'b0011, 32'h0,        32'h0000_8234, 1'b0, 3};
    vecs[7]  = '{"sb_lane1",  1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,        0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 2};
    vecs[8]  = '{"sz3_err",   1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
    vecs[9]  = '{"lw_stall",  1'b0, 2'd2, 1'b1, 32'h0000_0010, 32'h0,        32'h1234_5678, 2, 4'b1111, 32'h0,        32'h1234_5678, 1'b0, 5};
    vecs[10] = '{"sh_mis",    1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h0000_BEEF, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
    vecs[11] = '{"lb_s_pos",  1'b0, 2'd0, 1'b1, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 4'b0001, 32'h0,        32'h0000_007F, 1'b0, 3};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.readdata = '0; bus.waitrequest = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_strobes", {30'd0, bus.read, bus.write}, 32'd0);
    chk("rst_be", 32'(bus.byteenable), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].wr, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].stalls, 1'b0);
      check_txn(vecs[i].name, vecs[i].wr, vecs[i].a, vecs[i].stalls, vecs[i].be, vecs[i].wdl,
                vecs[i].rdx, vecs[i].err, vecs[i].lat);
    end

    // Reset in the middle of a stalled read
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h40;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.waitrequest = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_read_before", 32'(bus.read), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_read", 32'(bus.read), 32'd0);
    chk("rst_mid_resp", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid_ready_low", 32'(bus.req_ready), 32'd0);
    reset = 1'b0; bus.waitrequest = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_noresp", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid_noread", 32'(bus.read), 32'd0);

`ifdef MIPS_BUS_TIMEOUT_EN
    run_txn(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h5555_5555, 1000, 1'b0);
    chk("to_pulses", 32'(r_pulses), 32'd1);
    chk("to_err", 32'(r_err), 32'd1);
    chk("to_rdata", r_rdata, 32'd0);
    chk("to_buscyc", 32'(r_bus), 32'(TO));
`endif

    // Random traffic with junk requests driven while busy
    for (int i = 0; i < 150; i++) begin
      t_wr = 1'($urandom);
      t_sz = 2'($urandom);
      t_sx = 1'($urandom);
      t_a  = $urandom;
      t_wd = $urandom;
      t_rd = $urandom;
      t_st = int'($urandom_range(0, 3));
      model(t_wr, t_sz, t_sx, t_a, t_wd, t_rd, t_st, m_be, m_wdl, m_rdx, m_err, m_lat);
      run_txn(t_wr, t_sz, t_sx, t_a, t_wd, t_rd, t_st, 1'b1);
      check_txn($sformatf("rnd%0d", i), t_wr, t_a, t_st, m_be, m_wdl, m_rdx, m_err, m_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
